io_port8: RTL
=============

# io_port8

Memory-mapped I/O responder for the 8-bit-address single-cycle CPU. It decodes byte loads and stores in the top window 0xF8–0xFF and returns read data to the CPU's load path. It synchronises and edge-counts the external pulse sensor and drives an LED byte and a 4-digit multiplexed 7-segment display. It sits beside the data RAM; its SEL output steers the CPU read mux and blocks RAM writes in the window.

## Interface
- REFRESH_DIV, 1024: clock cycles per display digit slot; must be ≥2.
- SYNC_STAGES, 2: flops in the PULSE_IN synchroniser; must be ≥2.

- CLK in 1: clock; all state changes on rising edge.
- RESET in 1: reset RESET, synchronous, active-high; clock CLK.
- ADDR in 8: CPU byte address.
- WDATA in 8: store data (low byte of register).
- WE in 1: store-byte strobe, this cycle.
- RE in 1: load-byte strobe, this cycle.
- RDATA out 8: read data, combinational.
- SEL out 1: ADDR[7:3]==5'b11111, combinational, independent of RE/WE.
- PULSE_IN in 1: asynchronous sensor input.
- LED out 8: LED register.
- SEG out 7: {g,f,e,d,c,b,a}, active-low.
- AN out 4: digit enables, one-hot active-low.

## Operation
- Register map:
  - 0xFB STATUS (R): bit0 = synchronised level; bit1 = sticky rise flag; bits7:2 = 0.
  - 0xFC LED (R/W).
  - 0xFD EDGECNT (R): rising-edge count, saturating at 255. Any write clears it.
  - 0xFE DISP_HI (R/W).
  - 0xFF DISP_LO (R/W).
  - 0xF8–0xFA: read 0x00, writes ignored.
- RDATA = selected register when RE && SEL, else 0x00.
- Writes with WE && SEL take effect at the clock edge. Writes with SEL=0 are ignored.
- Sync chain of SYNC_STAGES flops, then a prev flop. rise = sync_last & ~prev.
- Rise flag:
  - Set on rise.
  - Cleared at the edge following a cycle with RE && ADDR==0xFB, unless rise occurs in that same cycle, in which case it stays 1.
- EDGECNT:
  - Increments on rise unless already 255.
  - A write to 0xFD coinciding with rise yields 1; the edge is never lost.
- RE and WE together on one address: RDATA shows the pre-write value.
- Display scan:
  - Counter runs 0..REFRESH_DIV-1. On wrap, digit index increments mod 4.
  - Digit 0 shows DISP_LO[3:0] with AN=1110.
  - Digit 1 shows DISP_LO[7:4] with AN=1101.
  - Digit 2 shows DISP_HI[3:0] with AN=1011.
  - Digit 3 shows DISP_HI[7:4] with AN=0111.
  - SEG = hex decode of the selected nibble (0–F).

## Timing
- Reset values:
  - LED, DISP_HI, DISP_LO, EDGECNT, rise flag, sync chain, prev, scan counter, digit index: all 0.
  - Hence LED=0x00, AN=1110, SEG=1000000 ("0").
- Reads have zero latency: RDATA is valid in the same cycle as ADDR/RE.
- A written value is visible on the next cycle's read and on LED/SEG after that edge.
- PULSE_IN timing:
  - A rise held stable appears in STATUS bit0 after SYNC_STAGES edges.
  - The flag and EDGECNT update at edge SYNC_STAGES+1.
  - A pulse shorter than one cycle may be missed. This is acceptable.
- Reset asserted mid-operation clears all state at that edge.
- If PULSE_IN is high through reset, one rise is counted SYNC_STAGES+1 edges after RESET deasserts.
- Digit slot length is exactly REFRESH_DIV cycles; the full frame is 4·REFRESH_DIV cycles.

## Structure
- Shared package io_pkg:
  - Address constants IO_STATUS=8'hFB, IO_LED=8'hFC, IO_EDGECNT=8'hFD, IO_DISP_HI=8'hFE, IO_DISP_LO=8'hFF.
  - IO_WINDOW=5'b11111.
  - STATUS bit indices.
- Sub-module hex7seg: combinational nibble to active-low {g..a}, shared with other display users.
- Synchroniser, edge logic, registers and scan counter live in io_port8.

## Test plan
- Reset, then idle 10 cycles → LED=0x00, AN=1110, SEG=1000000, every read in 0xF8–0xFF returns 0x00.
- Store 0xA5 to 0xFC, then load 0xFC → LED=0xA5 the cycle after the store, RDATA=0xA5. A store to 0xF9 leaves all registers unchanged.
- Three clean PULSE_IN pulses, each 5 cycles high and 5 low → EDGECNT=3. Load 0xFB reads bit1=1; the next load of 0xFB reads bit1=0. Flag first seen 3 edges after the first rise.
- Rise coincident with a 0xFB read-clear → flag stays 1. Rise coincident with a store to 0xFD → EDGECNT=1. 260 pulses → EDGECNT saturates at 255.
- REFRESH_DIV=4, DISP_HI=0x12, DISP_LO=0x3F → AN cycles 1110,1101,1011,0111 every 4 cycles, with SEG = F(0001110), 3(0110000), 2(0100100), 1(1111001).
- RESET asserted mid-count with PULSE_IN held high → all registers 0. EDGECNT=1 at 3 edges after RESET deasserts.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the CPU's memory-mapped I/O window (0xF8-0xFF).
package io_pkg;
  localparam logic [7:0] IO_STATUS  = 8'hFB;
  localparam logic [7:0] IO_LED     = 8'hFC;
  localparam logic [7:0] IO_EDGECNT = 8'hFD;
  localparam logic [7:0] IO_DISP_HI = 8'hFE;
  localparam logic [7:0] IO_DISP_LO = 8'hFF;

  // ADDR[7:3] value that selects the I/O window instead of data RAM.
  localparam logic [4:0] IO_WINDOW = 5'b11111;

  // STATUS register bit positions.
  localparam int STATUS_LEVEL_BIT = 0;
  localparam int STATUS_RISE_BIT  = 1;
endpackage

// File: rtl/io_port8_hex7seg.sv
// Nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}; shared by display users.
module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  // Pure lookup, hex digits 0-F with lowercase b and d.
  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/io_port8.sv
// Memory-mapped I/O responder: pulse sensor edge counter, LED byte and
// 4-digit multiplexed 7-segment display, decoded in the 0xF8-0xFF window.
// The CPU bus has no handshake: RE/WE are single-cycle strobes, RDATA is
// combinational in the same cycle, writes land at the closing clock edge.
module io_port8 import io_pkg::*; #(
  parameter int REFRESH_DIV = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic       WE,
  input  logic       RE,
  output logic [7:0] RDATA,
  output logic       SEL,
  input  logic       PULSE_IN,
  output logic [7:0] LED,
  output logic [6:0] SEG,
  output logic [3:0] AN
);
  localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_last;
  logic                   rise;
  logic                   rise_flag;
  logic [7:0]             edge_cnt;
  logic [7:0]             led_q;
  logic [7:0]             disp_hi;
  logic [7:0]             disp_lo;
  logic [SCAN_W-1:0]      scan_cnt;
  logic [1:0]             digit_idx;
  logic [3:0]             nibble;
  logic [7:0]             status;
  logic                   wr_en;
  logic                   status_rd;

  assign SEL       = (ADDR[7:3] == IO_WINDOW);
  assign wr_en     = WE && SEL;
  assign status_rd = RE && (ADDR == IO_STATUS);
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = sync_last && !prev_q;
  assign LED       = led_q;

  // Synchroniser chain plus a delayed copy for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PULSE_IN};
      prev_q <= sync_last;
    end
  end

  // Sticky rise flag: a new rise wins over a read-clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET)          rise_flag <= 1'b0;
    else if (rise)      rise_flag <= 1'b1;
    else if (status_rd) rise_flag <= 1'b0;
  end

  // Saturating edge counter; a clearing write keeps a coincident edge.
  always_ff @(posedge CLK) begin
    if (RESET)
      edge_cnt <= 8'h00;
    else if (wr_en && ADDR == IO_EDGECNT)
      edge_cnt <= rise ? 8'h01 : 8'h00;
    else if (rise && edge_cnt != 8'hFF)
      edge_cnt <= edge_cnt + 8'h01;
  end

  // CPU-writable data registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      led_q   <= 8'h00;
      disp_hi <= 8'h00;
      disp_lo <= 8'h00;
    end else if (wr_en) begin
      if (ADDR == IO_LED)     led_q   <= WDATA;
      if (ADDR == IO_DISP_HI) disp_hi <= WDATA;
      if (ADDR == IO_DISP_LO) disp_lo <= WDATA;
    end
  end

  // Display scan: each digit slot lasts exactly REFRESH_DIV cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Read mux; registers show pre-write contents when RE and WE coincide.
  always_comb begin
    status = 8'h00;
    status[STATUS_LEVEL_BIT] = sync_last;
    status[STATUS_RISE_BIT]  = rise_flag;
    RDATA = 8'h00;
    if (RE && SEL) begin
      case (ADDR)
        IO_STATUS:  RDATA = status;
        IO_LED:     RDATA = led_q;
        IO_EDGECNT: RDATA = edge_cnt;
        IO_DISP_HI: RDATA = disp_hi;
        IO_DISP_LO: RDATA = disp_lo;
        default:    RDATA = 8'h00;
      endcase
    end
  end

  // Digit select: anode one-hot active-low and the nibble it shows.
  always_comb begin
    AN     = 4'b1110;
    nibble = disp_lo[3:0];
    case (digit_idx)
      2'd0: begin AN = 4'b1110; nibble = disp_lo[3:0]; end
      2'd1: begin AN = 4'b1101; nibble = disp_lo[7:4]; end
      2'd2: begin AN = 4'b1011; nibble = disp_hi[3:0]; end
      2'd3: begin AN = 4'b0111; nibble = disp_hi[7:4]; end
      default: begin AN = 4'b1110; nibble = disp_lo[3:0]; end
    endcase
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (SEG)
  );
endmodule
